// File: rtl/rv_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding,
// one-hot opcode-class constants and instruction length constants.
package rv_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

  localparam int OPC_N = 11;

  // One-hot opcode classes; bit order matches the vector built in the top.
  localparam logic [OPC_N-1:0] OPC_RTYPE  = 11'b000_0000_0001;
  localparam logic [OPC_N-1:0] OPC_ITYPE  = 11'b000_0000_0010;
  localparam logic [OPC_N-1:0] OPC_LOAD   = 11'b000_0000_0100;
  localparam logic [OPC_N-1:0] OPC_STORE  = 11'b000_0000_1000;
  localparam logic [OPC_N-1:0] OPC_BRANCH = 11'b000_0001_0000;
  localparam logic [OPC_N-1:0] OPC_JAL    = 11'b000_0010_0000;
  localparam logic [OPC_N-1:0] OPC_JALR   = 11'b000_0100_0000;
  localparam logic [OPC_N-1:0] OPC_LUI    = 11'b000_1000_0000;
  localparam logic [OPC_N-1:0] OPC_AUIPC  = 11'b001_0000_0000;
  localparam logic [OPC_N-1:0] OPC_SYSTEM = 11'b010_0000_0000;
  localparam logic [OPC_N-1:0] OPC_FENCE  = 11'b100_0000_0000;

  localparam int ILEN_FULL = 4;
  localparam int ILEN_C    = 2;

  // True when the opcode vector contains the given class.
  function automatic logic opc_is(input logic [OPC_N-1:0] opc,
                                  input logic [OPC_N-1:0] cls);
    return |(opc & cls);
  endfunction

endpackage

// File: rtl/rv_retire_counter.sv
// Retired-instruction counter: wraps modulo 2^W, synchronous active-high reset.
module rv_retire_counter #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: add one on each committed instruction.
  always_comb begin
    count_d = count_q;
    if (i_inc) count_d = count_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/rv_writeback_unit.sv
// Final pipeline stage: selects the rd writeback value and the next PC
// (sequential, jump/branch target, trap entry, mret), stalls on load data,
// flags misaligned targets and counts retired instructions.
// Optional feature macro: RV_COMPRESSED_EN (16-bit instructions, pc+2 step,
// only bit 0 of a target checked for misalignment).
module rv_writeback_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              RETIRE_W = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ce,
  output logic                o_ce,
  output logic                o_stall,
  input  logic [2:0]          i_funct3,
  input  logic [4:0]          i_rd_addr,
  input  logic [XLEN-1:0]     i_alu_out,
  input  logic [XLEN-1:0]     i_imm,
  input  logic [XLEN-1:0]     i_rs1,
  input  logic [XLEN-1:0]     i_csr_out,
  input  logic [XLEN-1:0]     i_data_load,
  input  logic                i_data_load_valid,
  input  logic                i_opcode_rtype,
  input  logic                i_opcode_itype,
  input  logic                i_opcode_load,
  input  logic                i_opcode_store,
  input  logic                i_opcode_branch,
  input  logic                i_opcode_jal,
  input  logic                i_opcode_jalr,
  input  logic                i_opcode_lui,
  input  logic                i_opcode_auipc,
  input  logic                i_opcode_system,
  input  logic                i_opcode_fence,
  input  logic                i_insn_16b,
  input  logic                i_go_to_trap,
  input  logic                i_return_from_trap,
  input  logic [XLEN-1:0]     i_trap_address,
  input  logic [XLEN-1:0]     i_return_address,
  output logic [XLEN-1:0]     o_rd,
  output logic [4:0]          o_rd_addr,
  output logic                o_wr_rd,
  output logic [XLEN-1:0]     o_pc,
  output logic [XLEN-1:0]     o_next_pc,
  output logic                o_change_pc,
  output logic                o_misaligned,
  output logic [RETIRE_W-1:0] o_retired
);

  // Registered state
  wb_state_e       state_q,      state_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [XLEN-1:0] rd_q,         rd_d;
  logic [4:0]      rd_addr_q,    rd_addr_d;
  logic            wr_rd_q,      wr_rd_d;
  logic            ce_q,         ce_d;
  logic            misaligned_q, misaligned_d;

  // Opcode class decode
  logic [OPC_N-1:0] opc;
  logic is_rtype, is_itype, is_load, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_system;

  assign opc = {i_opcode_fence, i_opcode_system, i_opcode_auipc, i_opcode_lui,
                i_opcode_jalr, i_opcode_jal, i_opcode_branch, i_opcode_store,
                i_opcode_load, i_opcode_itype, i_opcode_rtype};

  assign is_rtype  = opc_is(opc, OPC_RTYPE);
  assign is_itype  = opc_is(opc, OPC_ITYPE);
  assign is_load   = opc_is(opc, OPC_LOAD);
  assign is_branch = opc_is(opc, OPC_BRANCH);
  assign is_jal    = opc_is(opc, OPC_JAL);
  assign is_jalr   = opc_is(opc, OPC_JALR);
  assign is_lui    = opc_is(opc, OPC_LUI);
  assign is_auipc  = opc_is(opc, OPC_AUIPC);
  assign is_system = opc_is(opc, OPC_SYSTEM);

  // Datapath signals
  logic [XLEN-1:0] seq_step;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_sum;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            mis_hit;
  logic [XLEN-1:0] wb_val;
  logic            wb_en;
  logic [XLEN-1:0] commit_pc;

`ifdef RV_COMPRESSED_EN
  assign seq_step = i_insn_16b ? XLEN'(ILEN_C) : XLEN'(ILEN_FULL);
`else
  logic unused_insn_16b;
  assign unused_insn_16b = i_insn_16b;
  assign seq_step        = XLEN'(ILEN_FULL);
`endif

  assign seq_pc = pc_q + seq_step;

  // One adder serves jal, jalr, branch targets and auipc; jalr swaps pc for rs1.
  assign add_a   = is_jalr ? i_rs1 : pc_q;
  assign add_sum = add_a + i_imm;
  assign target  = {add_sum[XLEN-1:1], add_sum[0] & ~is_jalr};

  assign taken = is_jal | is_jalr | (is_branch & i_alu_out[0]);

`ifdef RV_COMPRESSED_EN
  assign mis_hit = taken & target[0];
`else
  assign mis_hit = taken & target[1];
`endif

  assign commit_pc = (taken && !mis_hit) ? target : seq_pc;

  // Writeback value and write enable by opcode class.
  always_comb begin
    wb_val = '0;
    if (is_rtype || is_itype)               wb_val = i_alu_out;
    else if (is_load)                       wb_val = i_data_load;
    else if (is_jal || is_jalr)             wb_val = seq_pc;
    else if (is_lui)                        wb_val = i_imm;
    else if (is_auipc)                      wb_val = add_sum;
    else if (is_system && i_funct3 != 3'd0) wb_val = i_csr_out;
    wb_en = (is_rtype | is_itype | is_load | is_jal | is_jalr | is_lui | is_auipc |
             (is_system & (i_funct3 != 3'd0))) & (i_rd_addr != 5'd0);
  end

  // Control: priorities, stall, redirect and next-state for every register.
  logic trap_hit;
  logic ret_hit;
  logic load_miss;
  logic commit;

  assign trap_hit  = i_go_to_trap;
  assign ret_hit   = (state_q == RUN) & ~i_go_to_trap & i_return_from_trap;
  assign load_miss = is_load & ~i_data_load_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    rd_addr_d    = rd_addr_q;
    wr_rd_d      = wr_rd_q;
    misaligned_d = misaligned_q;
    commit       = 1'b0;

    o_stall = (state_q == LOAD_WAIT) |
              (i_ce & (state_q == RUN) & ~trap_hit & ~ret_hit & load_miss);

    if (trap_hit)                  o_next_pc = i_trap_address;
    else if (ret_hit)              o_next_pc = i_return_address;
    else if (o_stall || mis_hit)   o_next_pc = pc_q;
    else                           o_next_pc = commit_pc;

    o_change_pc = trap_hit | ret_hit | ((state_q == RUN) & taken & ~mis_hit);

    if (i_ce) begin
      wr_rd_d      = 1'b0;
      misaligned_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (trap_hit)       pc_d = i_trap_address;
          else if (ret_hit)   pc_d = i_return_address;
          else if (mis_hit)   misaligned_d = 1'b1;
          else if (load_miss) state_d = LOAD_WAIT;
          else                commit = 1'b1;
        end
        LOAD_WAIT: begin
          if (trap_hit) begin
            pc_d    = i_trap_address;
            state_d = RUN;
          end else if (i_data_load_valid) begin
            commit  = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
      if (commit) begin
        pc_d      = commit_pc;
        rd_d      = wb_val;
        rd_addr_d = i_rd_addr;
        wr_rd_d   = wb_en;
      end
    end

    ce_d = i_ce & (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= RUN;
      pc_q         <= PC_RESET;
      rd_q         <= '0;
      rd_addr_q    <= '0;
      wr_rd_q      <= 1'b0;
      ce_q         <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      rd_addr_q    <= rd_addr_d;
      wr_rd_q      <= wr_rd_d;
      ce_q         <= ce_d;
      misaligned_q <= misaligned_d;
    end
  end

  rv_retire_counter #(
    .W (RETIRE_W)
  ) u_retire (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (commit),
    .o_count (o_retired)
  );

  assign o_ce         = ce_q;
  assign o_rd         = rd_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_wr_rd      = wr_rd_q;
  assign o_pc         = pc_q;
  assign o_misaligned = misaligned_q;

endmodule
